// File: rtl/alu_pipe_param.sv
// alu_pipe_param: parametrised ALU core with operand wait, multi-cycle multiply
// and an OUT_VALID/BUSY handshake. All outputs are registered; CE=0 freezes everything.
module alu_pipe_param #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned CMD_W   = 4,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CE,
    input  logic               MODE,
    input  logic [CMD_W-1:0]   CMD,
    input  logic [1:0]         INP_VALID,
    input  logic [WIDTH-1:0]   OPA,
    input  logic [WIDTH-1:0]   OPB,
    input  logic               CIN,
    output logic               BUSY,
    output logic               OUT_VALID,
    output logic [2*WIDTH-1:0] RES,
    output logic               COUT,
    output logic               OFLOW,
    output logic               G,
    output logic               L,
    output logic               E,
    output logic               ERR
);

    localparam int unsigned RES_W   = 2 * WIDTH;
    localparam int unsigned SH_W    = $clog2(WIDTH);
    localparam int unsigned CNT_MAX = (TIMEOUT > MUL_LAT) ? TIMEOUT : MUL_LAT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_MUL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [RES_W-1:0] res;
        logic             cout;
        logic             oflow;
        logic             g;
        logic             l;
        logic             e;
        logic             err;
    } alu_out_t;

    // Command is legal for the selected mode
    function automatic logic cmd_ok(input logic mode, input int unsigned c);
        return mode ? (c <= 9) : (c <= 13);
    endfunction

    // Multiply is the only multi-cycle command
    function automatic logic is_mul(input logic mode, input int unsigned c);
        return mode && (c == 9);
    endfunction

    // Operands required by a command: bit0 = A, bit1 = B
    function automatic logic [1:0] need_ops(input logic mode, input int unsigned c);
        logic [1:0] n;
        n = 2'b00;
        if (mode) begin
            case (c)
                0, 1, 2, 3, 8, 9: n = 2'b11;
                4, 5:             n = 2'b01;
                6, 7:             n = 2'b10;
                default:          n = 2'b00;
            endcase
        end else begin
            case (c)
                0, 1, 2, 3, 4, 5, 12, 13: n = 2'b11;
                6, 8, 9:                  n = 2'b01;
                7, 10, 11:                n = 2'b10;
                default:                  n = 2'b00;
            endcase
        end
        return n;
    endfunction

    // Single-shot evaluation of one command on resolved operands
    function automatic alu_out_t alu_eval(input logic mode, input int unsigned c,
                                          input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b,
                                          input logic cin);
        alu_out_t         o;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] r;
        logic [WIDTH:0]   u;
        logic [RES_W-1:0] rot;
        logic             cy;
        logic             sub;
        logic             arith;
        o     = '0;
        x     = a;
        y     = b;
        r     = '0;
        u     = '0;
        rot   = '0;
        cy    = 1'b0;
        sub   = 1'b0;
        arith = 1'b0;
        if (mode) begin
            case (c)
                0: arith = 1'b1;
                1: begin arith = 1'b1; sub = 1'b1; end
                2: begin arith = 1'b1; cy = cin; end
                3: begin arith = 1'b1; sub = 1'b1; cy = cin; end
                4: begin arith = 1'b1; y = WIDTH'(1); end
                5: begin arith = 1'b1; sub = 1'b1; y = WIDTH'(1); end
                6: begin arith = 1'b1; x = b; y = WIDTH'(1); end
                7: begin arith = 1'b1; sub = 1'b1; x = b; y = WIDTH'(1); end
                8: begin
                    o.g = (a > b);
                    o.l = (a < b);
                    o.e = (a == b);
                end
                9: o.res = RES_W'(a) * RES_W'(b);
                default: o.err = 1'b1;
            endcase
            // Carry/borrow lands in RES[WIDTH]; overflow judged on the WIDTH-bit result
            if (arith) begin
                if (sub) begin
                    u       = {1'b0, x} - {1'b0, y} - (WIDTH+1)'(cy);
                    o.oflow = (x[WIDTH-1] != y[WIDTH-1]) && (u[WIDTH-1] != x[WIDTH-1]);
                end else begin
                    u       = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(cy);
                    o.oflow = (x[WIDTH-1] == y[WIDTH-1]) && (u[WIDTH-1] != x[WIDTH-1]);
                end
                o.res  = RES_W'(u);
                o.cout = u[WIDTH];
            end
        end else begin
            case (c)
                0:  r = a & b;
                1:  r = ~(a & b);
                2:  r = a | b;
                3:  r = ~(a | b);
                4:  r = a ^ b;
                5:  r = ~(a ^ b);
                6:  r = ~a;
                7:  r = ~b;
                8:  r = a >> 1;
                9:  r = a << 1;
                10: r = b >> 1;
                11: r = b << 1;
                12: begin
                    if (|b[WIDTH-1:SH_W]) begin
                        o.err = 1'b1;
                    end else begin
                        rot = {a, a} << b[SH_W-1:0];
                        r   = rot[RES_W-1:WIDTH];
                    end
                end
                13: begin
                    if (|b[WIDTH-1:SH_W]) begin
                        o.err = 1'b1;
                    end else begin
                        rot = {a, a} >> b[SH_W-1:0];
                        r   = rot[WIDTH-1:0];
                    end
                end
                default: o.err = 1'b1;
            endcase
            o.res = RES_W'(r);
        end
        return o;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CMD_W-1:0]   cmd_q, cmd_d;
    logic               mode_q, mode_d;
    logic               cin_q, cin_d;
    logic [1:0]         miss_q, miss_d;

    logic               busy_d, valid_d;
    logic [RES_W-1:0]   res_d;
    logic               cout_d, oflow_d, g_d, l_d, e_d, err_d;

    logic               exe_go;
    logic               exe_mode;
    logic [CMD_W-1:0]   exe_cmd;
    logic [WIDTH-1:0]   exe_a;
    logic [WIDTH-1:0]   exe_b;
    logic               exe_cin;
    logic [1:0]         miss;
    alu_out_t           alu_o;

    // State, operand latches and registered outputs; CE gates every update
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cmd_q     <= '0;
            mode_q    <= 1'b0;
            cin_q     <= 1'b0;
            miss_q    <= 2'b00;
            BUSY      <= 1'b0;
            OUT_VALID <= 1'b0;
            RES       <= '0;
            COUT      <= 1'b0;
            OFLOW     <= 1'b0;
            G         <= 1'b0;
            L         <= 1'b0;
            E         <= 1'b0;
            ERR       <= 1'b0;
        end else if (CE) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cmd_q     <= cmd_d;
            mode_q    <= mode_d;
            cin_q     <= cin_d;
            miss_q    <= miss_d;
            BUSY      <= busy_d;
            OUT_VALID <= valid_d;
            RES       <= res_d;
            COUT      <= cout_d;
            OFLOW     <= oflow_d;
            G         <= g_d;
            L         <= l_d;
            E         <= e_d;
            ERR       <= err_d;
        end
    end

    // Next-state, operand capture and result selection
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        cmd_d    = cmd_q;
        mode_d   = mode_q;
        cin_d    = cin_q;
        miss_d   = miss_q;
        busy_d   = BUSY;
        valid_d  = 1'b0;
        res_d    = RES;
        cout_d   = COUT;
        oflow_d  = OFLOW;
        g_d      = G;
        l_d      = L;
        e_d      = E;
        err_d    = ERR;
        exe_go   = 1'b0;
        exe_mode = MODE;
        exe_cmd  = CMD;
        exe_a    = OPA;
        exe_b    = OPB;
        exe_cin  = CIN;
        alu_o    = '0;
        miss     = need_ops(MODE, 32'(CMD)) & ~INP_VALID;

        case (state_q)
            S_IDLE: begin
                if (INP_VALID != 2'b00) begin
                    if (!cmd_ok(MODE, 32'(CMD))) begin
                        exe_go = 1'b1;
                    end else if (miss != 2'b00) begin
                        a_d     = OPA;
                        b_d     = OPB;
                        cmd_d   = CMD;
                        mode_d  = MODE;
                        cin_d   = CIN;
                        miss_d  = miss;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = S_WAIT;
                    end else if (is_mul(MODE, 32'(CMD))) begin
                        a_d     = OPA;
                        b_d     = OPB;
                        cmd_d   = CMD;
                        mode_d  = MODE;
                        cin_d   = CIN;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = S_MUL;
                    end else begin
                        exe_go = 1'b1;
                    end
                end
            end

            S_WAIT: begin
                exe_mode = mode_q;
                exe_cmd  = cmd_q;
                exe_cin  = cin_q;
                exe_a    = miss_q[0] ? OPA : a_q;
                exe_b    = miss_q[1] ? OPB : b_q;
                if ((INP_VALID & miss_q) == miss_q) begin
                    a_d   = exe_a;
                    b_d   = exe_b;
                    cnt_d = '0;
                    if (is_mul(mode_q, 32'(cmd_q))) begin
                        state_d = S_MUL;
                    end else begin
                        exe_go  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    valid_d = 1'b1;
                    res_d   = '0;
                    cout_d  = 1'b0;
                    oflow_d = 1'b0;
                    g_d     = 1'b0;
                    l_d     = 1'b0;
                    e_d     = 1'b0;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_MUL: begin
                exe_mode = mode_q;
                exe_cmd  = cmd_q;
                exe_a    = a_q;
                exe_b    = b_q;
                exe_cin  = cin_q;
                if (cnt_q == CNT_W'(MUL_LAT - 1)) begin
                    exe_go  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        if (exe_go) begin
            alu_o   = alu_eval(exe_mode, 32'(exe_cmd), exe_a, exe_b, exe_cin);
            valid_d = 1'b1;
            res_d   = alu_o.res;
            cout_d  = alu_o.cout;
            oflow_d = alu_o.oflow;
            g_d     = alu_o.g;
            l_d     = alu_o.l;
            e_d     = alu_o.e;
            err_d   = alu_o.err;
        end
    end

endmodule

// File: tb/tb_alu_pipe_param.sv
// Directed self-checking bench for alu_pipe_param at WIDTH=8, MUL_LAT=3, TIMEOUT=16.
module tb_alu_pipe_param;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CE;
    logic        MODE;
    logic [3:0]  CMD;
    logic [1:0]  INP_VALID;
    logic [7:0]  OPA;
    logic [7:0]  OPB;
    logic        CIN;
    logic        BUSY;
    logic        OUT_VALID;
    logic [15:0] RES;
    logic        COUT, OFLOW, G, L, E, ERR;

    int checks = 0;
    int errors = 0;

    alu_pipe_param #(
        .WIDTH   (8),
        .CMD_W   (4),
        .MUL_LAT (3),
        .TIMEOUT (16)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .CE        (CE),
        .MODE      (MODE),
        .CMD       (CMD),
        .INP_VALID (INP_VALID),
        .OPA       (OPA),
        .OPB       (OPB),
        .CIN       (CIN),
        .BUSY      (BUSY),
        .OUT_VALID (OUT_VALID),
        .RES       (RES),
        .COUT      (COUT),
        .OFLOW     (OFLOW),
        .G         (G),
        .L         (L),
        .E         (E),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;

    // Count one comparison and report it if it does not match
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic m, input logic [3:0] c, input logic [1:0] iv,
                         input logic [7:0] a, input logic [7:0] b, input logic ci);
        MODE = m; CMD = c; INP_VALID = iv; OPA = a; OPB = b; CIN = ci;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // A completed operation: pulse, result, flags, BUSY released
    task automatic expect_res(input string tag, input logic [15:0] r,
                              input logic co, input logic of, input logic er);
        check({tag, ".ov"},    32'(OUT_VALID), 32'd1);
        check({tag, ".res"},   32'(RES),       32'(r));
        check({tag, ".cout"},  32'(COUT),      32'(co));
        check({tag, ".oflow"}, 32'(OFLOW),     32'(of));
        check({tag, ".err"},   32'(ERR),       32'(er));
        check({tag, ".busy"},  32'(BUSY),      32'd0);
    endtask

    initial begin
        RST = 1'b0;
        CE  = 1'b1;
        drive(0, 0, 2'b00, 8'h00, 8'h00, 0);
        tick(); tick();
        check("rst.ov",   32'(OUT_VALID), 32'd0);
        check("rst.busy", 32'(BUSY),      32'd0);
        check("rst.res",  32'(RES),       32'd0);
        check("rst.err",  32'(ERR),       32'd0);
        RST = 1'b1;
        tick();

        // Arithmetic, back-to-back single-cycle ops
        drive(1, 0, 2'b11, 8'hFF, 8'h01, 0); tick(); expect_res("add_ff_01",  16'h0100, 1, 0, 0);
        drive(1, 0, 2'b11, 8'h7F, 8'h01, 0); tick(); expect_res("add_7f_01",  16'h0080, 0, 1, 0);
        drive(1, 1, 2'b11, 8'h10, 8'h20, 0); tick(); expect_res("sub_borrow", 16'h01F0, 1, 0, 0);
        drive(1, 1, 2'b11, 8'h80, 8'h01, 0); tick(); expect_res("sub_ovf",    16'h007F, 0, 1, 0);
        drive(1, 2, 2'b11, 8'h10, 8'h20, 1); tick(); expect_res("addc",       16'h0031, 0, 0, 0);
        drive(1, 3, 2'b11, 8'h10, 8'h05, 1); tick(); expect_res("subc",       16'h000A, 0, 0, 0);
        drive(0, 0, 2'b00, 8'h00, 8'h00, 0); tick();
        check("idle.ov", 32'(OUT_VALID), 32'd0);

        // Compare flags
        drive(1, 8, 2'b11, 8'h05, 8'h03, 0); tick();
        check("cmp_gt.g", 32'(G), 32'd1); check("cmp_gt.l", 32'(L), 32'd0); check("cmp_gt.e", 32'(E), 32'd0);
        drive(1, 8, 2'b11, 8'h03, 8'h05, 0); tick();
        check("cmp_lt.l", 32'(L), 32'd1); check("cmp_lt.g", 32'(G), 32'd0);
        drive(1, 8, 2'b11, 8'h44, 8'h44, 0); tick();
        check("cmp_eq.e", 32'(E), 32'd1); check("cmp_eq.res", 32'(RES), 32'd0);

        // Logical, shifts, rotates, invalid commands
        drive(0, 1,  2'b11, 8'hF0, 8'h3C, 0); tick(); expect_res("nand",    16'h00CF, 0, 0, 0);
        drive(0, 11, 2'b10, 8'h00, 8'h81, 0); tick(); expect_res("shl1_b",  16'h0002, 0, 0, 0);
        drive(0, 8,  2'b01, 8'h81, 8'h00, 0); tick(); expect_res("shr1_a",  16'h0040, 0, 0, 0);
        drive(0, 12, 2'b11, 8'h81, 8'h01, 0); tick(); expect_res("rol",     16'h0003, 0, 0, 0);
        drive(0, 13, 2'b11, 8'h81, 8'h01, 0); tick(); expect_res("ror",     16'h00C0, 0, 0, 0);
        drive(0, 12, 2'b11, 8'h81, 8'h09, 0); tick(); expect_res("rol_rng", 16'h0000, 0, 0, 1);
        drive(0, 15, 2'b01, 8'h12, 8'h00, 0); tick(); expect_res("bad_l15", 16'h0000, 0, 0, 1);
        drive(1, 12, 2'b11, 8'h12, 8'h34, 0); tick(); expect_res("bad_a12", 16'h0000, 0, 0, 1);

        // Multiply: BUSY for MUL_LAT cycles, commands during BUSY ignored
        drive(1, 9, 2'b11, 8'hFF, 8'hFF, 0); tick();
        check("mul.busy0", 32'(BUSY), 32'd1); check("mul.ov0", 32'(OUT_VALID), 32'd0);
        drive(1, 0, 2'b11, 8'h01, 8'h01, 0); tick();
        check("mul.busy1", 32'(BUSY), 32'd1); check("mul.ov1", 32'(OUT_VALID), 32'd0);
        tick();
        check("mul.busy2", 32'(BUSY), 32'd1);
        drive(0, 0, 2'b00, 8'h00, 8'h00, 0); tick();
        expect_res("mul_ff", 16'hFE01, 0, 0, 0);
        tick();
        check("mul.ovdrop", 32'(OUT_VALID), 32'd0);

        // Multiply with two frozen cycles, then CE=0 holds the result pulse
        drive(1, 9, 2'b11, 8'h12, 8'h34, 0); tick();
        drive(0, 0, 2'b00, 8'h00, 8'h00, 0);
        CE = 1'b0; tick(); tick();
        check("mulce.busy", 32'(BUSY), 32'd1);
        CE = 1'b1; tick(); tick();
        check("mulce.ov4", 32'(OUT_VALID), 32'd0);
        tick();
        expect_res("mulce", 16'h03A8, 0, 0, 0);
        CE = 1'b0; tick();
        check("hold.ov",  32'(OUT_VALID), 32'd1);
        check("hold.res", 32'(RES),       32'h03A8);
        CE = 1'b1; tick();
        check("hold.ovdrop", 32'(OUT_VALID), 32'd0);

        // Late operand: B arrives 5 cycles after A, CMD change and OPA ignored
        drive(0, 4, 2'b01, 8'hAA, 8'h00, 0); tick();
        check("wait.busy", 32'(BUSY), 32'd1); check("wait.ov", 32'(OUT_VALID), 32'd0);
        drive(0, 0, 2'b00, 8'h00, 8'h00, 0);
        repeat (4) tick();
        check("wait.busy4", 32'(BUSY), 32'd1);
        drive(0, 0, 2'b10, 8'h55, 8'h0F, 0); tick();
        expect_res("xor_wait", 16'h00A5, 0, 0, 0);
        drive(0, 0, 2'b00, 8'h00, 8'h00, 0); tick();
        check("wait.after_busy", 32'(BUSY), 32'd0);

        // Operand timeout clears stale compare flags
        drive(1, 8, 2'b11, 8'h05, 8'h03, 0); tick();
        check("pre_to.g", 32'(G), 32'd1);
        drive(1, 8, 2'b01, 8'h33, 8'h00, 0); tick();
        drive(0, 0, 2'b00, 8'h00, 8'h00, 0);
        repeat (15) tick();
        check("to.ov15",   32'(OUT_VALID), 32'd0);
        check("to.busy15", 32'(BUSY),      32'd1);
        tick();
        expect_res("timeout", 16'h0000, 0, 0, 1);
        check("to.g", 32'(G), 32'd0); check("to.l", 32'(L), 32'd0); check("to.e", 32'(E), 32'd0);
        drive(1, 0, 2'b11, 8'h03, 8'h04, 0); tick();
        expect_res("add_after_to", 16'h0007, 0, 0, 0);

        // Reset in the middle of a multiply
        drive(1, 9, 2'b11, 8'hFF, 8'hFF, 0); tick();
        drive(0, 0, 2'b00, 8'h00, 8'h00, 0); tick();
        RST = 1'b0;
        #1;
        check("rstmul.res",  32'(RES),       32'd0);
        check("rstmul.busy", 32'(BUSY),      32'd0);
        check("rstmul.ov",   32'(OUT_VALID), 32'd0);
        tick();
        RST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rstmul.no_ov", 32'(OUT_VALID), 32'd0);
        end
        drive(1, 0, 2'b11, 8'h03, 8'h04, 0); tick();
        expect_res("add_after_rst", 16'h0007, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
